accel_sequencer: RTL and testbench

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

---
 rtl/accel_sequencer_pkg.sv | 54 +++++
 rtl/accel_cmd_rom.sv | 31 +++
 rtl/accel_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_accel_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/accel_sequencer_pkg.sv
// Shared definitions for the accelerometer sequencer.
// Holds the FSM state encoding, the sensor register map and init values,
// the command word field positions, and a helper that packs a command word.
// No ports; imported by accel_cmd_rom and accel_sequencer.
package accel_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_POLL_WAIT,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_PUBLISH,
        ST_ABORT
    } seq_state_t;

    // Sensor register addresses
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    // Values written during initialisation
    localparam logic [7:0] DATA_FORMAT_VAL = 8'h08;
    localparam logic [7:0] BW_RATE_VAL     = 8'h0A;
    localparam logic [7:0] POWER_CTL_VAL   = 8'h08;

    // Command word layout
    localparam int CMD_RW_BIT   = 15;
    localparam int CMD_MB_BIT   = 14;
    localparam int CMD_ADDR_MSB = 13;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_MSB = 7;
    localparam int CMD_DATA_LSB = 0;

    // Table lengths and the index width that covers both tables
    localparam int INIT_LEN = 3;
    localparam int READ_LEN = 6;
    localparam int IDX_W    = $clog2(READ_LEN);

    function automatic logic [15:0] make_cmd(input logic       rw,
                                             input logic [5:0] addr,
                                             input logic [7:0] data);
        logic [15:0] c;
        c = '0;
        c[CMD_RW_BIT]                  = rw;
        c[CMD_MB_BIT]                  = 1'b0;
        c[CMD_ADDR_MSB:CMD_ADDR_LSB]   = addr;
        c[CMD_DATA_MSB:CMD_DATA_LSB]   = data;
        return c;
    endfunction

endpackage

// File: rtl/accel_cmd_rom.sv
// Combinational command table for the accelerometer sequencer.
// Ports:
//   is_read - 1 selects the read table (DATAX0..DATAZ1), 0 the init table
//   index   - table entry
//   cmd     - 16-bit command word for the selected entry (0 when out of range)
module accel_cmd_rom
    import accel_sequencer_pkg::*;
(
    input  logic             is_read,
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      cmd
);

    always_comb begin
        cmd = '0;
        if (is_read) begin
            // Reads walk consecutive data registers starting at DATAX0
            if (index < IDX_W'(READ_LEN)) begin
                cmd = make_cmd(1'b1, REG_DATAX0 + 6'(index), 8'h00);
            end
        end else begin
            case (index)
                IDX_W'(0): cmd = make_cmd(1'b0, REG_DATA_FORMAT, DATA_FORMAT_VAL);
                IDX_W'(1): cmd = make_cmd(1'b0, REG_BW_RATE,     BW_RATE_VAL);
                IDX_W'(2): cmd = make_cmd(1'b0, REG_POWER_CTL,   POWER_CTL_VAL);
                default:   cmd = '0;
            endcase
        end
    end

endmodule

// File: rtl/accel_sequencer.sv
// Accelerometer transaction sequencer.
// Runs an init write table through an SPI master, then periodically reads
// the six data registers and publishes complete X/Y/Z samples.
// Ports:
//   clk_i, rst_n_i        - clock, asynchronous active-low reset
//   en_i                  - run enable (level)
//   req_o, cmd_o          - one-cycle request and command word to SPI master
//   ack_i, rdata_i        - completion pulse and read byte from SPI master
//   x_o, y_o, z_o         - published signed samples
//   sample_valid_o        - one-cycle pulse when samples update
//   init_done_o           - init table acknowledged
//   error_o               - sticky ack-timeout flag
module accel_sequencer
    import accel_sequencer_pkg::*;
#(
    parameter int POLL_DIV = 500000,
    parameter int TIMEOUT  = 200000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic        req_o,
    output logic [15:0] cmd_o,
    input  logic        ack_i,
    input  logic [7:0]  rdata_i,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic [15:0] z_o,
    output logic        sample_valid_o,
    output logic        init_done_o,
    output logic        error_o
);

    localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [POLL_W-1:0] poll_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    // The last read byte goes straight from rdata_i into z_o, so only
    // five bytes need shadowing.
    logic [7:0]        shadow_q [READ_LEN-1];

    logic              rom_is_read;
    logic [15:0]       rom_cmd;
    logic              in_wait;
    logic              to_hit;
    logic              enter_abort;
    logic              poll_done;
    logic              last_init;
    logic              last_read;

    accel_cmd_rom u_rom (
        .is_read (rom_is_read),
        .index   (idx_q),
        .cmd     (rom_cmd)
    );

    assign in_wait     = (state_q == ST_INIT_WAIT) || (state_q == ST_RD_WAIT);
    // The timeout counter is loaded with 1 in the req_o cycle, so it holds
    // the number of cycles elapsed since the request.
    assign to_hit      = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign enter_abort = in_wait && !ack_i && to_hit;
    assign poll_done   = (poll_cnt_q == POLL_W'(POLL_DIV - 1));
    assign last_init   = (idx_q == IDX_W'(INIT_LEN - 1));
    assign last_read   = (idx_q == IDX_W'(READ_LEN - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the state-decoded outputs. cmd_o is held from the
    // ISSUE cycle through the end of WAIT because idx_q only moves on ack.
    always_comb begin
        state_d        = state_q;
        req_o          = 1'b0;
        cmd_o          = '0;
        sample_valid_o = 1'b0;
        rom_is_read    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = init_done_o ? ST_POLL_WAIT : ST_INIT_ISSUE;
                end
            end
            ST_INIT_ISSUE: begin
                req_o   = 1'b1;
                cmd_o   = rom_cmd;
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                cmd_o = rom_cmd;
                if (ack_i) begin
                    state_d = last_init ? ST_POLL_WAIT : ST_INIT_ISSUE;
                end else if (to_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_POLL_WAIT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (poll_done) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                rom_is_read = 1'b1;
                req_o       = 1'b1;
                cmd_o       = rom_cmd;
                state_d     = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rom_is_read = 1'b1;
                cmd_o       = rom_cmd;
                if (ack_i) begin
                    state_d = last_read ? ST_PUBLISH : ST_RD_ISSUE;
                end else if (to_hit) begin
                    state_d = ST_ABORT;
                end
            end
            ST_PUBLISH: begin
                sample_valid_o = 1'b1;
                state_d        = en_i ? ST_POLL_WAIT : ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters, table index, read shadow bytes and the published samples.
    // Samples are loaded on the final read ack so they appear together with
    // sample_valid_o in PUBLISH; error_o and init_done_o change on the edge
    // into ABORT so the abort cycle already shows them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q       <= '0;
            poll_cnt_q  <= '0;
            to_cnt_q    <= '0;
            x_o         <= '0;
            y_o         <= '0;
            z_o         <= '0;
            init_done_o <= 1'b0;
            error_o     <= 1'b0;
            for (int i = 0; i < READ_LEN - 1; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (state_q == ST_POLL_WAIT) begin
                poll_cnt_q <= poll_done ? '0 : poll_cnt_q + POLL_W'(1);
            end else begin
                poll_cnt_q <= '0;
            end

            if ((state_q == ST_INIT_ISSUE) || (state_q == ST_RD_ISSUE)) begin
                to_cnt_q <= TO_W'(1);
            end else if (in_wait) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end

            if (in_wait && ack_i) begin
                if ((state_q == ST_INIT_WAIT && last_init) ||
                    (state_q == ST_RD_WAIT && last_read)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else if ((state_q == ST_POLL_WAIT) || (state_q == ST_ABORT)) begin
                idx_q <= '0;
            end

            if (state_q == ST_RD_WAIT && ack_i) begin
                if (last_read) begin
                    x_o <= {shadow_q[1], shadow_q[0]};
                    y_o <= {shadow_q[3], shadow_q[2]};
                    z_o <= {rdata_i, shadow_q[4]};
                end else begin
                    for (int i = 0; i < READ_LEN - 1; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_q[i] <= rdata_i;
                        end
                    end
                end
            end

            if (state_q == ST_INIT_WAIT && ack_i && last_init) begin
                init_done_o <= 1'b1;
            end else if (enter_abort) begin
                init_done_o <= 1'b0;
            end

            if (enter_abort) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed self-checking testbench for accel_sequencer.
// Acts as the SPI master: waits for req_o, checks the command, holds off
// for a chosen number of cycles, then pulses ack_i with a read byte.
module tb_accel_sequencer;

    localparam int POLL_DIV = 20;
    localparam int TIMEOUT  = 100;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic        req_o;
    logic [15:0] cmd_o;
    logic        ack_i;
    logic [7:0]  rdata_i;
    logic [15:0] x_o;
    logic [15:0] y_o;
    logic [15:0] z_o;
    logic        sample_valid_o;
    logic        init_done_o;
    logic        error_o;

    int checks   = 0;
    int failures = 0;

    accel_sequencer #(
        .POLL_DIV (POLL_DIV),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .en_i           (en_i),
        .req_o          (req_o),
        .cmd_o          (cmd_o),
        .ack_i          (ack_i),
        .rdata_i        (rdata_i),
        .x_o            (x_o),
        .y_o            (y_o),
        .z_o            (z_o),
        .sample_valid_o (sample_valid_o),
        .init_done_o    (init_done_o),
        .error_o        (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Every comparison goes through here so the counts stay consistent
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
            $error("[TB] check %s observed=0x%04h expected=0x%04h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ack, input logic [7:0] rd);
        en_i    = en;
        ack_i   = ack;
        rdata_i = rd;
    endtask

    // Returns the number of falling edges waited until req_o is seen
    // (0 if it is already high); bounded so a silent DUT cannot hang the run
    task automatic waitReq(input string tag, output int waited);
        waited = 0;
        while (!req_o && waited < 300) begin
            @(negedge clk_i);
            waited++;
        end
        checkOutput({tag, "_seen"}, {15'd0, req_o}, 16'd1);
    endtask

    task automatic noReqFor(input string tag, input int n);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (req_o) pulses++;
        end
        checkOutput(tag, 16'(pulses), 16'd0);
    endtask

    // One complete transaction; ack arrives 'delay' cycles after req_o.
    // Returns on the falling edge after the ack cycle.
    task automatic serveTxn(input string tag, input logic [15:0] expCmd, input int delay,
                            input logic [7:0] rd, input logic dropEn);
        int   waited;
        logic stable;
        waitReq(tag, waited);
        checkOutput({tag, "_cmd"}, cmd_o, expCmd);
        if (dropEn) en_i = 1'b0;
        @(negedge clk_i);
        checkOutput({tag, "_req1cyc"}, {15'd0, req_o}, 16'd0);
        stable = 1'b1;
        for (int i = 1; i < delay; i++) begin
            if (cmd_o !== expCmd || req_o !== 1'b0) stable = 1'b0;
            @(negedge clk_i);
        end
        applyStimulus(en_i, 1'b1, rd);
        if (cmd_o !== expCmd) stable = 1'b0;
        checkOutput({tag, "_stable"}, {15'd0, stable}, 16'd1);
        @(negedge clk_i);
        applyStimulus(en_i, 1'b0, 8'h00);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"},   {15'd0, req_o}, 16'd0);
        checkOutput({tag, "_cmd"},   cmd_o, 16'h0000);
        checkOutput({tag, "_x"},     x_o, 16'h0000);
        checkOutput({tag, "_y"},     y_o, 16'h0000);
        checkOutput({tag, "_z"},     z_o, 16'h0000);
        checkOutput({tag, "_valid"}, {15'd0, sample_valid_o}, 16'd0);
        checkOutput({tag, "_init"},  {15'd0, init_done_o}, 16'd0);
        checkOutput({tag, "_err"},   {15'd0, error_o}, 16'd0);
    endtask

    logic [7:0] rdA [6];
    logic [7:0] rdB [6];

    initial begin
        int w;
        rdA = '{8'h10, 8'h01, 8'hF0, 8'hFF, 8'h00, 8'h01};
        rdB = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

        // Power-on reset
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkResetValues("por");
        rst_n_i = 1'b1;
        noReqFor("idle_disabled", 5);

        // Init table, acks 40 cycles after each request
        en_i = 1'b1;
        serveTxn("init0", 16'h3108, 40, 8'h00, 1'b0);
        serveTxn("init1", 16'h2C0A, 40, 8'h00, 1'b0);
        serveTxn("init2", 16'h2D08, 40, 8'h00, 1'b0);
        checkOutput("init_done", {15'd0, init_done_o}, 16'd1);

        // First poll: POLL_DIV cycles of POLL_WAIT before the burst
        waitReq("poll1", w);
        checkOutput("poll1_latency", 16'(w), 16'd20);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) checkOutput("x_hold_partial", x_o, 16'h0000);
            serveTxn($sformatf("rdA%0d", i), 16'hB200 + 16'(i) * 16'h0100, 3, rdA[i], 1'b0);
        end
        checkOutput("pubA_valid", {15'd0, sample_valid_o}, 16'd1);
        checkOutput("pubA_x", x_o, 16'h0110);
        checkOutput("pubA_y", y_o, 16'hFFF0);
        checkOutput("pubA_z", z_o, 16'h0100);
        @(negedge clk_i);
        checkOutput("pubA_pulse_end", {15'd0, sample_valid_o}, 16'd0);

        // Spurious ack while polling is ignored
        applyStimulus(1'b1, 1'b1, 8'hAA);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("spur_req", {15'd0, req_o}, 16'd0);
        checkOutput("spur_valid", {15'd0, sample_valid_o}, 16'd0);
        checkOutput("spur_x", x_o, 16'h0110);
        waitReq("poll2", w);
        checkOutput("poll2_latency", 16'(w), 16'd19);

        // Second burst; enable drops at read index 3 but the burst completes
        for (int i = 0; i < 6; i++) begin
            serveTxn($sformatf("rdB%0d", i), 16'hB200 + 16'(i) * 16'h0100, 2, rdB[i], i == 3);
        end
        checkOutput("pubB_valid", {15'd0, sample_valid_o}, 16'd1);
        checkOutput("pubB_x", x_o, 16'h1234);
        checkOutput("pubB_y", y_o, 16'h5678);
        checkOutput("pubB_z", z_o, 16'h9ABC);
        noReqFor("idle_after_drop", 60);

        // Reset in the middle of a read wait
        en_i = 1'b1;
        waitReq("rst_rd", w);
        @(negedge clk_i);
        checkOutput("rst_rd_wait_cmd", cmd_o, 16'hB200);
        rst_n_i = 1'b0;
        #1;
        checkResetValues("midrst");
        en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        noReqFor("post_rst_idle", 30);

        // Re-init, then withhold the second write's ack
        en_i = 1'b1;
        serveTxn("reinit0", 16'h3108, 5, 8'h00, 1'b0);
        waitReq("wd", w);
        checkOutput("wd_cmd", cmd_o, 16'h2C0A);
        w = 0;
        while (!error_o && w < 300) begin
            @(negedge clk_i);
            w++;
        end
        checkOutput("timeout_cycles", 16'(w), 16'd100);
        checkOutput("timeout_err", {15'd0, error_o}, 16'd1);
        checkOutput("timeout_init", {15'd0, init_done_o}, 16'd0);

        // Retry starts from the top of the table; error stays sticky
        serveTxn("retry0", 16'h3108, 5, 8'h00, 1'b0);
        serveTxn("retry1", 16'h2C0A, 5, 8'h00, 1'b0);
        serveTxn("retry2", 16'h2D08, 5, 8'h00, 1'b0);
        checkOutput("retry_init_done", {15'd0, init_done_o}, 16'd1);
        checkOutput("err_sticky", {15'd0, error_o}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
